// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and FSM state type for the UART transmit arbiter.
// The optional grant timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_W          = 8;
  localparam int unsigned UART_CLOCK_FREQUENCY = 25_125_000;
  localparam int unsigned UART_BAUD_RATE       = 9600;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the arbiter, grouped with master/slave views.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned REQ_ID_W = 2
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_ready;
    logic                           tx_valid;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           busy;
    logic [REQ_ID_W-1:0]            grant_id;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, busy, grant_id
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1,
// wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        o_valid = 1'b0;
        o_idx   = i_ptr;
        // k = NUM_REQ revisits ptr itself, so it ends up lowest priority.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[IDX_W'(cand)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one uart_tx among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to revoke grants whose owner stalls for TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned REQ_ID_W       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2617
) (
    input  logic clock,
    input  logic reset,
    uart_tx_arbiter_if.slave bus
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic timeout_flag
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << REQ_ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    arb_state_e             r_state, w_state_d;
    logic [REQ_ID_W-1:0]    r_grant_id, w_grant_id_d;
    logic [REQ_ID_W-1:0]    r_rr_ptr, w_rr_ptr_d;
    logic                   r_busy, w_busy_d;
    logic                   w_pick_valid;
    logic [REQ_ID_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic                   w_tx_valid;
    logic [UART_DATA_W-1:0] w_tx_data;
    logic                   w_xfer;
    logic [UART_DATA_W-1:0] w_req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign w_req_bytes[i] = bus.req_data[UART_DATA_W*i +: UART_DATA_W];
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_ID_W)
    ) u_picker (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt_d;
    logic            r_timeout_flag;
    logic            w_tmo_hit;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_grant_id_d = r_grant_id;
        w_rr_ptr_d   = r_rr_ptr;
        w_busy_d     = r_busy;
        w_req_ready  = '0;
        w_tx_valid   = 1'b0;
        w_tx_data    = '0;
        w_xfer       = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        w_tmo_cnt_d  = r_tmo_cnt;
        w_tmo_hit    = 1'b0;
`endif
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_id_d = w_pick_idx;
                    w_busy_d     = 1'b1;
                    w_state_d    = ARB_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
                    w_tmo_cnt_d  = '0;
`endif
                end
            end
            ARB_GRANT: begin
                w_tx_valid              = bus.req_valid[r_grant_id];
                w_tx_data               = w_tx_valid ? w_req_bytes[r_grant_id] : '0;
                w_req_ready[r_grant_id] = bus.tx_ready;
                w_xfer                  = w_tx_valid & bus.tx_ready;
                if (w_xfer && bus.req_last[r_grant_id]) begin
                    w_rr_ptr_d = r_grant_id;
                    w_busy_d   = 1'b0;
                    w_state_d  = ARB_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                if (w_xfer) begin
                    w_tmo_cnt_d = '0;
                end else if (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES)) begin
                    // Abandon the partial message; owner becomes lowest priority.
                    w_tmo_hit   = 1'b1;
                    w_tmo_cnt_d = '0;
                    w_rr_ptr_d  = r_grant_id;
                    w_busy_d    = 1'b0;
                    w_state_d   = ARB_IDLE;
                end else if (!w_tx_valid) begin
                    w_tmo_cnt_d = r_tmo_cnt + 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= REQ_ID_W'(NUM_REQ - 1);
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_grant_id <= w_grant_id_d;
            r_rr_ptr   <= w_rr_ptr_d;
            r_busy     <= w_busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmo_cnt      <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_tmo_cnt      <= w_tmo_cnt_d;
            r_timeout_flag <= r_timeout_flag | w_tmo_hit;
        end
    end

    assign timeout_flag = r_timeout_flag;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.tx_valid  = w_tx_valid;
    assign bus.tx_data   = w_tx_data;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters).
// Timeout scenario runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .REQ_ID_W(2)) bus ();

`ifdef UART_ARB_TIMEOUT_EN
    logic timeout_flag;
`endif

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .REQ_ID_W       (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] data, input logic last);
        bus.req_data[8*idx +: 8] = data;
        bus.req_last[idx]        = last;
    endtask

    int bp_bad_valid;
    int bp_bad_data;
    int bp_bad_ready;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        #3;
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_req_ready", bus.req_ready, 0);
        tick();
        reset = 1'b0;

        // Single requester: CC then 33(last)
        set_req(0, 8'hCC, 1'b0);
        bus.req_valid = 4'b0001;
        #1;
        check("idle_tx_valid", bus.tx_valid, 0);
        tick();
        check("single_grant_id", bus.grant_id, 0);
        check("single_busy", bus.busy, 1);
        check("single_tx_valid", bus.tx_valid, 1);
        check("single_tx_data_cc", bus.tx_data, 8'hCC);
        check("single_ready_lo", bus.req_ready, 4'b0000);
        bus.tx_ready = 1'b1;
        #1;
        check("single_ready_hi", bus.req_ready, 4'b0001);
        tick();
        bus.tx_ready = 1'b0;
        set_req(0, 8'h33, 1'b1);
        #1;
        check("single_tx_data_33", bus.tx_data, 8'h33);
        check("single_busy_mid", bus.busy, 1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready  = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        check("single_busy_fall", bus.busy, 0);
        check("single_tx_valid_idle", bus.tx_valid, 0);
        check("single_grant_kept", bus.grant_id, 0);

        // Contention r1 vs r3, single-byte messages
        set_req(1, 8'h11, 1'b1);
        set_req(3, 8'h3C, 1'b1);
        bus.req_valid = 4'b1010;
        bus.tx_ready  = 1'b1;
        tick();
        check("cont_grant_r1", bus.grant_id, 1);
        check("cont_data_r1", bus.tx_data, 8'h11);
        check("cont_ready_r1", bus.req_ready, 4'b0010);
        tick();
        check("cont_idle_busy", bus.busy, 0);
        tick();
        check("cont_grant_r3", bus.grant_id, 3);
        check("cont_data_r3", bus.tx_data, 8'h3C);
        check("cont_ready_r3", bus.req_ready, 4'b1000);
        tick();
        tick();
        check("cont_regrant_r1", bus.grant_id, 1);
        tick();
        bus.req_valid = 4'b0000;
        bus.tx_ready  = 1'b0;
        tick();

        // Atomicity: r0 sends A5,5A,FF while r2 waits
        set_req(0, 8'hA5, 1'b0);
        bus.req_valid = 4'b0001;
        tick();
        check("atom_grant_r0", bus.grant_id, 0);
        set_req(2, 8'hEE, 1'b0);
        bus.req_valid = 4'b0101;
        bus.tx_ready  = 1'b1;
        #1;
        check("atom_data_a5", bus.tx_data, 8'hA5);
        check("atom_ready_a5", bus.req_ready, 4'b0001);
        tick();
        set_req(0, 8'h5A, 1'b0);
        #1;
        check("atom_data_5a", bus.tx_data, 8'h5A);
        check("atom_ready_5a", bus.req_ready, 4'b0001);
        tick();
        set_req(0, 8'hFF, 1'b1);
        #1;
        check("atom_data_ff", bus.tx_data, 8'hFF);
        check("atom_grant_hold", bus.grant_id, 0);
        tick();
        bus.req_valid = 4'b0100;
        bus.tx_ready  = 1'b0;
        #1;
        check("atom_idle_ready", bus.req_ready, 4'b0000);
        tick();
        check("atom_grant_r2", bus.grant_id, 2);
        check("atom_data_r2", bus.tx_data, 8'hEE);

        // Backpressure: 50 cycles of tx_ready=0 on r2
        bp_bad_valid = 0;
        bp_bad_data  = 0;
        bp_bad_ready = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_valid !== 1'b1) bp_bad_valid++;
            if (bus.tx_data !== 8'hEE) bp_bad_data++;
            if (bus.req_ready !== 4'b0000) bp_bad_ready++;
            tick();
        end
        check("bp_tx_valid_held", bp_bad_valid, 0);
        check("bp_tx_data_stable", bp_bad_data, 0);
        check("bp_no_ready", bp_bad_ready, 0);
        check("bp_grant_held", bus.grant_id, 2);
        bus.tx_ready = 1'b1;
        #1;
        check("bp_ready_release", bus.req_ready, 4'b0100);
        tick();
        bus.tx_ready = 1'b0;
        set_req(2, 8'h77, 1'b0);
        #1;
        check("bp_next_byte", bus.tx_data, 8'h77);

        // Reset mid-message while r2 granted
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tx_valid", bus.tx_valid, 0);
        check("mid_rst_tx_data", bus.tx_data, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_grant_id", bus.grant_id, 0);
        tick();
        reset = 1'b0;
        set_req(0, 8'h01, 1'b1);
        bus.req_valid = 4'b0101;
        tick();
        check("post_rst_grant_r0", bus.grant_id, 0);
        check("post_rst_data_r0", bus.tx_data, 8'h01);

`ifdef UART_ARB_TIMEOUT_EN
        reset = 1'b1;
        #1;
        check("tmo_flag_rst", timeout_flag, 0);
        tick();
        reset = 1'b0;
        set_req(1, 8'h42, 1'b0);
        bus.req_valid = 4'b0010;
        tick();
        check("tmo_grant_r1", bus.grant_id, 1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready  = 1'b0;
        set_req(2, 8'h99, 1'b1);
        bus.req_valid = 4'b0100;
        begin
            int n;
            n = 0;
            while (bus.busy === 1'b1 && n < 40) begin
                tick();
                n++;
            end
            check("tmo_released_in_budget", (n < 40) ? 1 : 0, 1);
            check("tmo_flag_set", timeout_flag, 1);
            check("tmo_busy", bus.busy, 0);
        end
        tick();
        check("tmo_grant_r2", bus.grant_id, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
